main: RTL and testbench



---
 rtl/main.sv | 114 +++++++++++
 tb/tb_main.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/main.sv
// Switch-driven decoder demo: picks one of four 4-bit functions of sw and shows it on digit 0.
// Build option MAIN_LED_MIRROR_EN: led mirrors the raw switches instead of {mode, 0000, value}.
module main (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] sw,
   output logic [9:0] led,
   output logic [6:0] hex,
   output logic [7:0] hex_on
);

   localparam int unsigned SW_W  = 10;
   localparam int unsigned V_W   = 4;
   localparam int unsigned SEG_W = 7;
   localparam int unsigned DIG_W = 8;

   localparam logic [SW_W-1:0]  LED_RST    = SW_W'(0);
   localparam logic [SEG_W-1:0] SEG_BLANK  = 7'h7F;
   localparam logic [DIG_W-1:0] DIG_OFF    = 8'hFF;
   localparam logic [DIG_W-1:0] DIG0_ON    = 8'b1111_1110;
   localparam logic [V_W-1:0]   THERM_BAD  = 4'hE;

   logic [V_W-1:0]   w_therm;
   logic [V_W-1:0]   w_prio;
   logic [V_W-1:0]   w_func;
   logic [V_W-1:0]   w_v;
   logic [SEG_W-1:0] w_seg;
   logic [SW_W-1:0]  w_led;

   logic [SW_W-1:0]  r_led;
   logic [SEG_W-1:0] r_hex;
   logic [DIG_W-1:0] r_hex_on;

   // Thermometer code on the low nibble; any non-thermometer pattern flags E.
   always_comb begin
      w_therm = THERM_BAD;
      case (sw[3:0])
         4'b0000: w_therm = 4'd0;
         4'b0001: w_therm = 4'd1;
         4'b0011: w_therm = 4'd2;
         4'b0111: w_therm = 4'd3;
         4'b1111: w_therm = 4'd4;
         default: w_therm = THERM_BAD;
      endcase
   end

   // Highest set bit of the upper nibble, one-based; zero when the nibble is clear.
   always_comb begin
      w_prio = 4'd0;
      if (sw[7])      w_prio = 4'd4;
      else if (sw[6]) w_prio = 4'd3;
      else if (sw[5]) w_prio = 4'd2;
      else if (sw[4]) w_prio = 4'd1;
   end

   assign w_func = {3'b000, (sw[0] ^ sw[1]) | (sw[2] & sw[3])};

   always_comb begin
      w_v = 4'd0;
      case (sw[9:8])
         2'b00:   w_v = w_therm;
         2'b01:   w_v = w_prio;
         2'b10:   w_v = w_func;
         default: w_v = sw[3:0];
      endcase
   end

   // Active-low {g,f,e,d,c,b,a} segment patterns.
   always_comb begin
      w_seg = SEG_BLANK;
      case (w_v)
         4'h0: w_seg = 7'h40;
         4'h1: w_seg = 7'h79;
         4'h2: w_seg = 7'h24;
         4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;
         4'h5: w_seg = 7'h12;
         4'h6: w_seg = 7'h02;
         4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;
         4'h9: w_seg = 7'h10;
         4'hA: w_seg = 7'h08;
         4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;
         4'hD: w_seg = 7'h21;
         4'hE: w_seg = 7'h06;
         default: w_seg = 7'h0E;
      endcase
   end

`ifdef MAIN_LED_MIRROR_EN
   assign w_led = sw;
`else
   assign w_led = {sw[9:8], 4'b0000, w_v};
`endif

   // Single output stage; reset overrides whatever the switches say.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_led    <= LED_RST;
         r_hex    <= SEG_BLANK;
         r_hex_on <= DIG_OFF;
      end else begin
         r_led    <= w_led;
         r_hex    <= w_seg;
         r_hex_on <= DIG0_ON;
      end
   end

   assign led    = r_led;
   assign hex    = r_hex;
   assign hex_on = r_hex_on;

endmodule

// File: tb/tb_main.sv
// Self-checking bench for main: vector table plus reset/sweep sequences, checked through an expect queue.
module tb_main;

   logic       clk;
   logic       rst;
   logic [9:0] sw;
   logic [9:0] led;
   logic [6:0] hex;
   logic [7:0] hex_on;

   main dut (
      .clk    (clk),
      .rst    (rst),
      .sw     (sw),
      .led    (led),
      .hex    (hex),
      .hex_on (hex_on)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [6:0] hex;
      logic [7:0] hex_on;
      logic [9:0] led;
   } exp_t;

   typedef struct {
      logic [9:0] sw;
      logic [3:0] v;
      logic [6:0] hex;
   } vec_t;

   exp_t       q[$];
   vec_t       vt[22];
   logic [6:0] seg[16];
   int         n_checks;
   int         n_fail;

   localparam exp_t RST_EXP = '{hex: 7'h7F, hex_on: 8'hFF, led: 10'h000};

   function automatic exp_t mk_exp(input logic [9:0] s, input logic [3:0] v, input logic [6:0] h);
      exp_t e;
      e.hex    = h;
      e.hex_on = 8'hFE;
`ifdef MAIN_LED_MIRROR_EN
      e.led    = s;
`else
      e.led    = {s[9:8], 4'b0000, v};
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive away from the active edge, then compare the oldest expectation just after it.
   task automatic step(input logic r, input logic [9:0] s, input exp_t e, input string tag);
      exp_t x;
      @(negedge clk);
      rst = r;
      sw  = s;
      q.push_back(e);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: expectation queue empty", tag);
      end else begin
         x = q.pop_front();
         chk({tag, ".hex"},    10'(hex),    10'(x.hex));
         chk({tag, ".hex_on"}, 10'(hex_on), 10'(x.hex_on));
         chk({tag, ".led"},    led,         x.led);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      sw       = 10'h000;

      seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      // mode 00: thermometer
      vt[0]  = '{10'h000, 4'h0, 7'h40};
      vt[1]  = '{10'h001, 4'h1, 7'h79};
      vt[2]  = '{10'h003, 4'h2, 7'h24};
      vt[3]  = '{10'h007, 4'h3, 7'h30};
      vt[4]  = '{10'h00F, 4'h4, 7'h19};
      vt[5]  = '{10'h005, 4'hE, 7'h06};
      vt[6]  = '{10'h0F3, 4'h2, 7'h24};
      // mode 01: priority encoder, low nibble ignored
      vt[7]  = '{10'h100, 4'h0, 7'h40};
      vt[8]  = '{10'h120, 4'h2, 7'h24};
      vt[9]  = '{10'h1D0, 4'h4, 7'h19};
      vt[10] = '{10'h1F0, 4'h4, 7'h19};
      vt[11] = '{10'h1D5, 4'h4, 7'h19};
      vt[12] = '{10'h1DA, 4'h4, 7'h19};
      vt[13] = '{10'h110, 4'h1, 7'h79};
      // mode 10: (s0^s1)|(s2&s3), upper nibble ignored
      vt[14] = '{10'h200, 4'h0, 7'h40};
      vt[15] = '{10'h205, 4'h1, 7'h79};
      vt[16] = '{10'h20A, 4'h1, 7'h79};
      vt[17] = '{10'h20F, 4'h1, 7'h79};
      vt[18] = '{10'h20C, 4'h1, 7'h79};
      vt[19] = '{10'h203, 4'h0, 7'h40};
      vt[20] = '{10'h2F3, 4'h0, 7'h40};
      // straight back to mode 00 from mode 10
      vt[21] = '{10'h00E, 4'hE, 7'h06};

      step(1'b1, 10'h000, RST_EXP, "reset");
      step(1'b0, 10'h000, mk_exp(10'h000, 4'h0, 7'h40), "first");

      for (int i = 0; i < 22; i++)
         step(1'b0, vt[i].sw, mk_exp(vt[i].sw, vt[i].v, vt[i].hex), $sformatf("vec%0d", i));

      // mode 11 sweep, upper nibble set to show it is ignored
      for (int n = 0; n < 16; n++) begin
         logic [9:0] s;
         s = {2'b11, 4'hA, 4'(n)};
         step(1'b0, s, mk_exp(s, 4'(n), seg[n]), $sformatf("pass%0d", n));
      end

      // reset mid-operation, then recovery
      step(1'b0, 10'h308, mk_exp(10'h308, 4'h8, 7'h00), "pre_rst");
      step(1'b1, 10'h308, RST_EXP, "mid_rst");
      step(1'b1, 10'h3FF, RST_EXP, "rst_hold");
      step(1'b0, 10'h308, mk_exp(10'h308, 4'h8, 7'h00), "post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
